riscv_rom_loader: RTL and testbench

RISCV_ROM_LOADER -- requirements
Module: riscv_rom_loader

---
 rtl/riscv_rom_loader.sv | 258 +++++++++++++++++++++++++
 tb/tb_riscv_rom_loader.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_rom_loader.sv
// UART boot loader: receives an 0xA5-framed image over 8N1 serial, writes it to ROM as 64-bit words, then releases the core.
// Build option: define RISCV_ROM_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte (CHECK state).
module riscv_rom_loader #(
  parameter int CLKS_PER_BIT   = 434,
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int MAX_WORDS      = 1024
) (
  input  logic        clk,
  input  logic        srst,
  input  logic        rx,
  output logic [31:0] rom_waddr,
  output logic [63:0] rom_wdata,
  output logic        rom_wen,
  output logic        core_srst_n,
  output logic        load_done,
  output logic        load_error
);

  localparam int CNT_W  = $clog2(CLKS_PER_BIT + 1);
  localparam int HALF   = (CLKS_PER_BIT / 2 > 0) ? CLKS_PER_BIT / 2 : 1;
  localparam int TMO_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam int WIDX_W = $clog2(MAX_WORDS + 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF - 1);
  localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [31:0]      MAX_N     = 32'(MAX_WORDS);
  localparam logic [7:0]       MAGIC     = 8'hA5;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;
  typedef enum logic [2:0] {IDLE, LEN_LO, LEN_HI, DATA, CHECK, DONE} state_e;

  rx_state_e        rx_state_q;
  logic             rx_meta_q;
  logic             rx_sync_q;
  logic             rx_prev_q;
  logic [CNT_W-1:0] clk_cnt_q;
  logic [2:0]       bit_idx_q;
  logic [7:0]       shift_q;
  logic             byte_vld_q;
  logic             byte_ferr_q;
  logic [7:0]       byte_q;

  state_e            state_q;
  logic [7:0]        len_lo_q;
  logic [15:0]       len_q;
  logic [WIDX_W-1:0] word_idx_q;
  logic [2:0]        byte_cnt_q;
  logic [63:0]       asm_q;
  logic [TMO_W-1:0]  tmo_q;
  logic              rom_wen_q;
  logic [31:0]       rom_waddr_q;
  logic [63:0]       rom_wdata_q;
  logic              core_srst_n_q;
  logic              load_done_q;
  logic              load_error_q;
`ifdef RISCV_ROM_LOADER_CHECKSUM_EN
  logic [7:0]        csum_q;
`endif

  logic [63:0] asm_d;
  logic [15:0] len_d;
  logic        len_bad;
  logic        last_word;
  logic        active;
  logic        byte_ok;
  logic        frame_err;

  // Serial receiver: 2-flop synchronizer, falling-edge start, mid-bit sampling.
  always_ff @(posedge clk) begin
    if (srst) begin
      rx_meta_q   <= 1'b1;
      rx_sync_q   <= 1'b1;
      rx_prev_q   <= 1'b1;
      rx_state_q  <= RX_IDLE;
      clk_cnt_q   <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      byte_vld_q  <= 1'b0;
      byte_ferr_q <= 1'b0;
      byte_q      <= '0;
    end else begin
      rx_meta_q  <= rx;
      rx_sync_q  <= rx_meta_q;
      rx_prev_q  <= rx_sync_q;
      byte_vld_q <= 1'b0;
      case (rx_state_q)
        RX_IDLE: begin
          if (rx_prev_q && !rx_sync_q) begin
            rx_state_q <= RX_START;
            clk_cnt_q  <= '0;
          end
        end
        RX_START: begin
          if (clk_cnt_q == HALF_LAST) begin
            clk_cnt_q  <= '0;
            bit_idx_q  <= '0;
            rx_state_q <= rx_sync_q ? RX_IDLE : RX_DATA;
          end else begin
            clk_cnt_q <= clk_cnt_q + CNT_W'(1);
          end
        end
        RX_DATA: begin
          if (clk_cnt_q == BIT_LAST) begin
            clk_cnt_q <= '0;
            shift_q   <= {rx_sync_q, shift_q[7:1]};
            bit_idx_q <= bit_idx_q + 3'd1;
            if (bit_idx_q == 3'd7) rx_state_q <= RX_STOP;
          end else begin
            clk_cnt_q <= clk_cnt_q + CNT_W'(1);
          end
        end
        RX_STOP: begin
          if (clk_cnt_q == BIT_LAST) begin
            clk_cnt_q   <= '0;
            byte_vld_q  <= 1'b1;
            byte_q      <= shift_q;
            byte_ferr_q <= !rx_sync_q;
            rx_state_q  <= RX_IDLE;
          end else begin
            clk_cnt_q <= clk_cnt_q + CNT_W'(1);
          end
        end
        default: rx_state_q <= RX_IDLE;
      endcase
    end
  end

  assign asm_d     = {byte_q, asm_q[63:8]};
  assign len_d     = {byte_q, len_lo_q};
  assign len_bad   = (len_d == 16'd0) || (32'(len_d) > MAX_N);
  assign last_word = (32'(word_idx_q) + 32'd1) == 32'(len_q);
  assign active    = state_q inside {LEN_LO, LEN_HI, DATA, CHECK};
  assign byte_ok   = byte_vld_q && !byte_ferr_q;

  // A completed byte always wins over a timeout expiring in the same cycle.
  always_comb begin
    frame_err = 1'b0;
    if (active) begin
      if (byte_vld_q) begin
        if (byte_ferr_q) begin
          frame_err = 1'b1;
        end else if (state_q == LEN_HI && len_bad) begin
          frame_err = 1'b1;
`ifdef RISCV_ROM_LOADER_CHECKSUM_EN
        end else if (state_q == CHECK && byte_q != csum_q) begin
          frame_err = 1'b1;
`endif
        end
      end else if (tmo_q == TMO_LAST) begin
        frame_err = 1'b1;
      end
    end
  end

  // Frame FSM with registered ROM write port and status outputs.
  always_ff @(posedge clk) begin
    if (srst) begin
      state_q       <= IDLE;
      len_lo_q      <= '0;
      len_q         <= '0;
      word_idx_q    <= '0;
      byte_cnt_q    <= '0;
      asm_q         <= '0;
      tmo_q         <= '0;
      rom_wen_q     <= 1'b0;
      rom_waddr_q   <= '0;
      rom_wdata_q   <= '0;
      core_srst_n_q <= 1'b0;
      load_done_q   <= 1'b0;
      load_error_q  <= 1'b0;
`ifdef RISCV_ROM_LOADER_CHECKSUM_EN
      csum_q        <= '0;
`endif
    end else begin
      rom_wen_q <= 1'b0;
      if (active) tmo_q <= byte_vld_q ? '0 : tmo_q + TMO_W'(1);
      if (frame_err) begin
        state_q      <= IDLE;
        load_error_q <= 1'b1;
        word_idx_q   <= '0;
        byte_cnt_q   <= '0;
        tmo_q        <= '0;
`ifdef RISCV_ROM_LOADER_CHECKSUM_EN
        csum_q       <= '0;
`endif
      end else begin
        case (state_q)
          IDLE: begin
            if (byte_ok && byte_q == MAGIC) begin
              state_q      <= LEN_LO;
              load_error_q <= 1'b0;
              tmo_q        <= '0;
              word_idx_q   <= '0;
              byte_cnt_q   <= '0;
`ifdef RISCV_ROM_LOADER_CHECKSUM_EN
              csum_q       <= '0;
`endif
            end
          end
          LEN_LO: begin
            if (byte_ok) begin
              len_lo_q <= byte_q;
              state_q  <= LEN_HI;
            end
          end
          LEN_HI: begin
            if (byte_ok) begin
              len_q      <= len_d;
              word_idx_q <= '0;
              byte_cnt_q <= '0;
              state_q    <= DATA;
            end
          end
          DATA: begin
            if (byte_ok) begin
              asm_q      <= asm_d;
              byte_cnt_q <= byte_cnt_q + 3'd1;
`ifdef RISCV_ROM_LOADER_CHECKSUM_EN
              csum_q     <= csum_q ^ byte_q;
`endif
              if (byte_cnt_q == 3'd7) begin
                rom_wen_q   <= 1'b1;
                rom_waddr_q <= 32'(word_idx_q) << 3;
                rom_wdata_q <= asm_d;
                word_idx_q  <= word_idx_q + WIDX_W'(1);
                if (last_word) begin
`ifdef RISCV_ROM_LOADER_CHECKSUM_EN
                  state_q <= CHECK;
`else
                  state_q <= DONE;
`endif
                end
              end
            end
          end
`ifdef RISCV_ROM_LOADER_CHECKSUM_EN
          CHECK: begin
            if (byte_ok) state_q <= DONE;
          end
`endif
          DONE: begin
            load_done_q   <= 1'b1;
            core_srst_n_q <= 1'b1;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign rom_wen     = rom_wen_q;
  assign rom_waddr   = rom_waddr_q;
  assign rom_wdata   = rom_wdata_q;
  assign core_srst_n = core_srst_n_q;
  assign load_done   = load_done_q;
  assign load_error  = load_error_q;

endmodule

// File: tb/tb_riscv_rom_loader.sv
// Randomized self-checking bench for riscv_rom_loader; frames and expected ROM writes come from a byte-level model.
module tb_riscv_rom_loader;
  localparam int CPB  = 4;
  localparam int TMO  = 200;
  localparam int MAXW = 1024;

  logic        clk  = 1'b0;
  logic        srst = 1'b1;
  logic        rx   = 1'b1;
  logic [31:0] rom_waddr;
  logic [63:0] rom_wdata;
  logic        rom_wen;
  logic        core_srst_n;
  logic        load_done;
  logic        load_error;

  riscv_rom_loader #(
    .CLKS_PER_BIT  (CPB),
    .TIMEOUT_CYCLES(TMO),
    .MAX_WORDS     (MAXW)
  ) dut (
    .clk        (clk),
    .srst       (srst),
    .rx         (rx),
    .rom_waddr  (rom_waddr),
    .rom_wdata  (rom_wdata),
    .rom_wen    (rom_wen),
    .core_srst_n(core_srst_n),
    .load_done  (load_done),
    .load_error (load_error)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int stop_cyc = 0;
  int wen_run = 0;
  int bad_pulse = 0;
  int last_wen_cyc = -1;
  int done_cyc = -1;
  logic done_prev = 1'b0;

  logic [95:0] wr_q[$];
  logic [95:0] exp_wr[$];
  logic [7:0]  frame_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Write monitor: captures every strobe and flags strobes longer than one cycle.
  always @(negedge clk) begin
    if (rom_wen === 1'b1) begin
      wr_q.push_back({rom_waddr, rom_wdata});
      last_wen_cyc = cyc;
      wen_run++;
      if (wen_run > 1) bad_pulse++;
    end else begin
      wen_run = 0;
    end
    if (load_done === 1'b1 && !done_prev) done_cyc = cyc;
    done_prev = (load_done === 1'b1);
  end

  task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic uart_send(input logic [7:0] b, input logic stop_ok);
    @(negedge clk);
    rx = 1'b0;
    repeat (CPB - 1) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    stop_cyc = cyc;
    rx = stop_ok;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
    repeat (2 * CPB) @(negedge clk);
  endtask

  task automatic send_bytes(input logic [7:0] bs[$]);
    foreach (bs[i]) uart_send(bs[i], 1'b1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    srst = 1'b1;
    rx   = 1'b1;
    repeat (2) @(negedge clk);
    srst = 1'b0;
    wr_q.delete();
  endtask

  task automatic wait_for(input string tag, input logic want_err, input int budget);
    int t;
    t = 0;
    while (((want_err ? load_error : load_done) !== 1'b1) && t < budget) begin
      @(negedge clk);
      t++;
    end
    if (t >= budget) chk({tag, "_wait"}, 96'd0, 96'd1);
  endtask

  task automatic check_writes(input string tag);
    chk({tag, "_nwr"}, 96'(wr_q.size()), 96'(exp_wr.size()));
    for (int i = 0; i < exp_wr.size() && i < wr_q.size(); i++)
      chk({tag, "_wr"}, wr_q[i], exp_wr[i]);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_wen"},   96'(rom_wen), 96'd0);
    chk({tag, "_waddr"}, 96'(rom_waddr), 96'd0);
    chk({tag, "_wdata"}, 96'(rom_wdata), 96'd0);
    chk({tag, "_core"},  96'(core_srst_n), 96'd0);
    chk({tag, "_done"},  96'(load_done), 96'd0);
    chk({tag, "_err"},   96'(load_error), 96'd0);
  endtask

  // Reference model: frame = A5, N little-endian, N*8 data bytes, optional XOR byte.
  task automatic build_frame(input int n, input logic corrupt);
    logic [7:0]  cs;
    logic [7:0]  b;
    logic [63:0] w;
    cs = 8'h00;
    frame_q.delete();
    exp_wr.delete();
    frame_q.push_back(8'hA5);
    frame_q.push_back(n[7:0]);
    frame_q.push_back(n[15:8]);
    for (int i = 0; i < n; i++) begin
      w = 64'd0;
      for (int k = 0; k < 8; k++) begin
        b = 8'($urandom);
        frame_q.push_back(b);
        cs = cs ^ b;
        w = w | (64'(b) << (8 * k));
      end
      exp_wr.push_back({32'(i * 8), w});
    end
`ifdef RISCV_ROM_LOADER_CHECKSUM_EN
    frame_q.push_back(corrupt ? ~cs : cs);
`else
    if (corrupt) frame_q.push_back(cs);
`endif
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] g;
    int n;
    logic bad;

    srst = 1'b1;
    rx   = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    srst = 1'b0;
    wr_q.delete();

    // Single-word image.
    frame_q = '{8'hA5, 8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
`ifdef RISCV_ROM_LOADER_CHECKSUM_EN
    frame_q.push_back(8'h88);
`endif
    exp_wr.delete();
    exp_wr.push_back({32'h0, 64'h8877665544332211});
    send_bytes(frame_q);
    wait_for("one_word", 1'b0, 60);
    check_writes("one_word");
    chk("one_word_done", 96'(load_done), 96'd1);
    chk("one_word_core", 96'(core_srst_n), 96'd1);
    chk("one_word_err",  96'(load_error), 96'd0);
`ifndef RISCV_ROM_LOADER_CHECKSUM_EN
    chk("done_after_wen", 96'(done_cyc - last_wen_cyc), 96'd1);
`endif
    send_bytes(frame_q);
    repeat (20) @(negedge clk);
    chk("done_ignores_rx_nwr", 96'(wr_q.size()), 96'd1);
    chk("done_sticky", 96'(load_done), 96'd1);

`ifdef RISCV_ROM_LOADER_CHECKSUM_EN
    // Bad checksum, then a good frame.
    do_reset();
    frame_q[frame_q.size() - 1] = 8'h00;
    send_bytes(frame_q);
    wait_for("bad_csum", 1'b1, 60);
    chk("bad_csum_err",  96'(load_error), 96'd1);
    chk("bad_csum_core", 96'(core_srst_n), 96'd0);
    chk("bad_csum_done", 96'(load_done), 96'd0);
    frame_q[frame_q.size() - 1] = 8'h88;
    send_bytes(frame_q);
    wait_for("retry", 1'b0, 60);
    chk("retry_done", 96'(load_done), 96'd1);
    chk("retry_err",  96'(load_error), 96'd0);
`endif

    // Illegal word counts.
    do_reset();
    send_bytes('{8'hA5, 8'h00, 8'h00});
    wait_for("n_zero", 1'b1, 60);
    chk("n_zero_err", 96'(load_error), 96'd1);
    send_bytes('{8'hA5, 8'h01});
    chk("err_clear_on_magic", 96'(load_error), 96'd0);
    uart_send(8'h04, 1'b1);
    wait_for("n_big", 1'b1, 60);
    chk("n_big_err",  96'(load_error), 96'd1);
    chk("n_bad_nwr",  96'(wr_q.size()), 96'd0);
    chk("n_bad_core", 96'(core_srst_n), 96'd0);

    // Inter-byte timeout.
    do_reset();
    send_bytes('{8'hA5, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33});
    while (load_error !== 1'b1 && (cyc - stop_cyc) < TMO + 100) @(negedge clk);
    chk("tmo_not_early", 96'((cyc - stop_cyc) > TMO), 96'd1);
    chk("tmo_not_late",  96'((cyc - stop_cyc) <= TMO + CPB + 4), 96'd1);
    chk("tmo_err", 96'(load_error), 96'd1);
    chk("tmo_nwr", 96'(wr_q.size()), 96'd0);

    // Framing errors.
    do_reset();
    uart_send(8'h3C, 1'b0);
    repeat (10) @(negedge clk);
    chk("ferr_idle_clean", 96'(load_error), 96'd0);
    uart_send(8'hA5, 1'b1);
    uart_send(8'h01, 1'b0);
    repeat (10) @(negedge clk);
    chk("ferr_len_err", 96'(load_error), 96'd1);
    uart_send(8'h3C, 1'b0);
    repeat (10) @(negedge clk);
    chk("ferr_idle_keep", 96'(load_error), 96'd1);
    build_frame(1, 1'b0);
    send_bytes(frame_q);
    wait_for("ferr_recover", 1'b0, 60);
    chk("ferr_recover_done", 96'(load_done), 96'd1);
    check_writes("ferr_recover");

    // Reset in the middle of a two-word frame.
    do_reset();
    build_frame(2, 1'b0);
    for (int i = 0; i < 8; i++) uart_send(frame_q[i], 1'b1);
    @(negedge clk);
    srst = 1'b1;
    @(negedge clk);
    check_reset_vals("mid_reset");
    srst = 1'b0;
    repeat (20) @(negedge clk);
    chk("mid_reset_nwr", 96'(wr_q.size()), 96'd0);
    send_bytes(frame_q);
    wait_for("resend", 1'b0, 60);
    check_writes("resend");
    chk("resend_done", 96'(load_done), 96'd1);

    // Randomized frames with leading junk and, when checksums exist, random corruption.
    for (int it = 0; it < 8; it++) begin
      do_reset();
      n = $urandom_range(1, 3);
`ifdef RISCV_ROM_LOADER_CHECKSUM_EN
      bad = ($urandom_range(0, 2) == 0);
`else
      bad = 1'b0;
`endif
      build_frame(n, bad);
      for (int j = $urandom_range(0, 2); j > 0; j--) begin
        g = 8'($urandom);
        if (g == 8'hA5) g = 8'h5A;
        frame_q.push_front(g);
      end
      send_bytes(frame_q);
      wait_for("rand", bad, 80);
      check_writes("rand");
      chk("rand_done", 96'(load_done), 96'(!bad));
      chk("rand_err",  96'(load_error), 96'(bad));
      chk("rand_core", 96'(core_srst_n), 96'(!bad));
    end

    chk("wen_single_cycle", 96'(bad_pulse), 96'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
